// File: rtl/screen_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// screen_sequencer_pkg
// Shared definitions for the Pinball VGA game-flow logic:
//   - screen_t : screen selector for the top-level pixel mux
//   - *_DEFAULT: default frame/lives constants for screen_sequencer
//   - cnt_width: counter width needed to hold 0..max_val (at least 1 bit)
// ---------------------------------------------------------------------------
package screen_sequencer_pkg;

  typedef enum logic [1:0] {
    SCREEN_START = 2'd0,
    SCREEN_GAME  = 2'd1,
    SCREEN_END   = 2'd2
  } screen_t;

  localparam int LIVES_DEFAULT           = 3;
  localparam int SERVE_FRAMES_DEFAULT    = 60;
  localparam int END_HOLD_FRAMES_DEFAULT = 120;
  localparam int BLINK_FRAMES_DEFAULT    = 30;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
// Counts frame ticks from 0 up to MAX and saturates there.
// Ports:
//   clk, resetN : clock, asynchronous active-low reset
//   clr         : synchronous clear (wins over counting)
//   en          : counting enabled
//   tick        : one-cycle frame pulse (startOfFrame)
//   cnt         : current count, width cnt_width(MAX)
//   done        : cnt has reached MAX
// ---------------------------------------------------------------------------
module frame_timer
  import screen_sequencer_pkg::*;
#(
  parameter int MAX = 1,
  localparam int W  = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clr,
  input  logic         en,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output logic         done
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == MAX_C);

endmodule

// File: rtl/screen_sequencer.sv
// ---------------------------------------------------------------------------
// screen_sequencer
// Game-flow controller: picks the displayed screen, tracks lives, gates the
// game objects and blinks the word overlay. All timing counts startOfFrame.
// Ports:
//   clk, resetN   : clock, asynchronous active-low reset
//   startOfFrame  : one-cycle pulse per VGA frame
//   key_start     : debounced start key (level)
//   ball_lost     : one-cycle pulse when the ball leaves the table
//   screen_sel    : screen_t value for the screen mux
//   game_active   : game objects may move (only while playing)
//   game_restart  : one-cycle pulse on entry to play
//   lives         : remaining balls
//   word_visible  : word overlay enable
// Build option: define SCREEN_SEQ_BLINK_EN to enable the overlay blink;
// otherwise word_visible is tied to 1.
// ---------------------------------------------------------------------------
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int LIVES           = LIVES_DEFAULT,
  parameter int SERVE_FRAMES    = SERVE_FRAMES_DEFAULT,
  parameter int END_HOLD_FRAMES = END_HOLD_FRAMES_DEFAULT,
  parameter int BLINK_FRAMES    = BLINK_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       key_start,
  input  logic       ball_lost,
  output logic [1:0] screen_sel,
  output logic       game_active,
  output logic       game_restart,
  output logic [2:0] lives,
  output logic       word_visible
);

  typedef enum logic [1:0] {S_START, S_PLAY, S_SERVE, S_END} state_t;

  // One frame counter serves both the serve pause and the end-screen hold.
  localparam int FRAME_MAX = (SERVE_FRAMES - 1 > END_HOLD_FRAMES) ?
                             SERVE_FRAMES - 1 : END_HOLD_FRAMES;
  localparam int FW = cnt_width(FRAME_MAX);
  localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
  localparam logic [FW-1:0] END_HOLD   = FW'(END_HOLD_FRAMES);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

  state_t  state_q, state_d;
  logic    key_prev_q;
  logic    [2:0] lives_q, lives_d;
  screen_t screen_sel_q, screen_sel_d;
  logic    game_active_q, game_active_d;
  logic    game_restart_q, game_restart_d;

  logic          key_edge;
  logic          state_change;
  logic          frame_en;
  logic [FW-1:0] frame_cnt;
  logic          frame_done;
  logic          unused_frame_done;

  // key_prev resets to 1 so a key held through reset gives no edge.
  assign key_edge = key_start & ~key_prev_q;
  assign frame_en = (state_q == S_SERVE) || (state_q == S_END);
  assign unused_frame_done = frame_done;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    case (state_q)
      S_START: begin
        if (key_edge) begin
          state_d = S_PLAY;
          lives_d = LIVES_INIT;
        end
      end
      S_PLAY: begin
        // ball_lost has priority; key edges are not looked at here.
        if (ball_lost) begin
          if (lives_q == 3'd1) begin
            state_d = S_END;
            lives_d = '0;
          end else begin
            state_d = S_SERVE;
            lives_d = lives_q - 3'd1;
          end
        end
      end
      S_SERVE: begin
        if (startOfFrame && (frame_cnt == SERVE_LAST)) state_d = S_PLAY;
      end
      S_END: begin
        lives_d = '0;
        if (key_edge && (frame_cnt >= END_HOLD)) state_d = S_START;
      end
      default: state_d = S_START;
    endcase

    state_change   = (state_d != state_q);
    game_restart_d = state_change && (state_d == S_PLAY);
    game_active_d  = (state_d == S_PLAY);
    case (state_d)
      S_START: screen_sel_d = SCREEN_START;
      S_END:   screen_sel_d = SCREEN_END;
      default: screen_sel_d = SCREEN_GAME;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= S_START;
      key_prev_q     <= 1'b1;
      lives_q        <= '0;
      screen_sel_q   <= SCREEN_START;
      game_active_q  <= 1'b0;
      game_restart_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_prev_q     <= key_start;
      lives_q        <= lives_d;
      screen_sel_q   <= screen_sel_d;
      game_active_q  <= game_active_d;
      game_restart_q <= game_restart_d;
    end
  end

  // Cleared in the transition cycle so each state starts counting from 0.
  frame_timer #(.MAX(FRAME_MAX)) u_frame_timer (
    .clk    (clk),
    .resetN (resetN),
    .clr    (state_change),
    .en     (frame_en),
    .tick   (startOfFrame),
    .cnt    (frame_cnt),
    .done   (frame_done)
  );

`ifdef SCREEN_SEQ_BLINK_EN
  localparam int BW = cnt_width(BLINK_FRAMES - 1);

  logic          word_visible_q, word_visible_d;
  logic          blink_en;
  logic          blink_wrap;
  logic [BW-1:0] blink_cnt;
  logic          blink_done;
  logic          unused_blink_cnt;

  assign blink_en         = (state_q == S_START) || (state_q == S_END);
  assign blink_wrap       = blink_en && startOfFrame && blink_done;
  assign unused_blink_cnt = ^blink_cnt;

  always_comb begin
    word_visible_d = word_visible_q;
    if (state_change)    word_visible_d = 1'b1;
    else if (blink_wrap) word_visible_d = ~word_visible_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) word_visible_q <= 1'b1;
    else         word_visible_q <= word_visible_d;
  end

  // Wraps by clearing at BLINK_FRAMES-1 rather than running on to saturation.
  frame_timer #(.MAX(BLINK_FRAMES - 1)) u_blink_timer (
    .clk    (clk),
    .resetN (resetN),
    .clr    (state_change | blink_wrap),
    .en     (blink_en),
    .tick   (startOfFrame),
    .cnt    (blink_cnt),
    .done   (blink_done)
  );

  assign word_visible = word_visible_q;
`else
  assign word_visible = 1'b1;
`endif

  assign screen_sel   = screen_sel_q;
  assign game_active  = game_active_q;
  assign game_restart = game_restart_q;
  assign lives        = lives_q;

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Game-flow controller for the Pinball VGA pipeline. It selects which screen (start, game or end) the top-level pixel mux displays, and tracks lives from ball-loss events. It gates the game objects through `game_active` and `game_restart`, and drives the blink gating for the word overlay on the start and end screens. All timing is counted in frames using the VGA controller's `startOfFrame` pulse.

## Interface
Parameters:
- `LIVES`, 3: balls per game, range 1..7.
- `SERVE_FRAMES`, 60: frames paused after a lost ball before the next serve, ≥1.
- `END_HOLD_FRAMES`, 120: frames the end screen ignores the start key, ≥1.
- `BLINK_FRAMES`, 30: frames per word-visibility half-period, ≥1.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `startOfFrame`, in, 1: one-cycle pulse at the start of each VGA frame.
- `key_start`, in, 1: debounced start key, active-high level.
- `ball_lost`, in, 1: one-cycle pulse when the ball leaves the table.
- `screen_sel`, out, 2: `screen_t` value for the screen mux.
- `game_active`, out, 1: game objects may move.
- `game_restart`, out, 1: one-cycle pulse; game objects reload their initial positions.
- `lives`, out, 3: remaining balls.
- `word_visible`, out, 1: word overlay enable (blink).

## Operation
- States: `S_START`, `S_PLAY`, `S_SERVE`, `S_END`.
- `screen_sel` by state:
  - `S_START` → `SCREEN_START` (0).
  - `S_PLAY` and `S_SERVE` → `SCREEN_GAME` (1).
  - `S_END` → `SCREEN_END` (2).
  - Value 3 is never driven.
- `game_active` = 1 only in `S_PLAY`.
- Key edge: `key_edge = key_start & ~key_d`, where `key_d` is registered.
  - `key_d` resets to 1, so a key held through reset produces no edge.
- `S_START`: on `key_edge` → `S_PLAY`, `lives <= LIVES`, pulse `game_restart`.
- `S_PLAY` on `ball_lost`:
  - If `lives == 1` → `S_END` and `lives <= 0`.
  - Otherwise → `S_SERVE` and `lives <= lives - 1`.
  - `key_edge` is ignored in `S_PLAY`.
- `S_SERVE`:
  - `frame_cnt` is cleared on entry and increments on each `startOfFrame`.
  - On the `startOfFrame` where `frame_cnt == SERVE_FRAMES-1` → `S_PLAY`, pulse `game_restart`.
  - `ball_lost` and `key_edge` are ignored.
- `S_END`:
  - `frame_cnt` is cleared on entry and counts frames, saturating at `END_HOLD_FRAMES`.
  - `key_edge` while `frame_cnt < END_HOLD_FRAMES` is ignored.
  - Otherwise `key_edge` → `S_START`.
  - `lives` holds 0.
- Blink: a separate `blink_cnt` counts `startOfFrame` in `S_START` and `S_END`.
  - At `BLINK_FRAMES-1` it wraps to 0 and toggles `word_visible`.
  - On every state change, `blink_cnt` clears and `word_visible` is set to 1.
  - In `S_PLAY` and `S_SERVE`, `word_visible` is 1.
- Counter widths: `$clog2(max+1)` of the largest count each counter must hold. The counters saturate and never wrap past their terminal value.

## Timing
- Reset values:
  - State `S_START`, `screen_sel` = 0.
  - `game_active` = 0, `game_restart` = 0.
  - `lives` = 0, `word_visible` = 1.
  - `frame_cnt` = 0, `blink_cnt` = 0, `key_d` = 1.
- All outputs are registered. A triggering input at cycle N is visible on the outputs at N+1.
- `game_restart` is high for exactly the first cycle of `S_PLAY`, in the same cycle that `game_active` first rises.
- If `ball_lost` coincides with the `S_SERVE`→`S_PLAY` transition, it is ignored; it is sampled only while in `S_PLAY`.
- If `ball_lost` and `key_edge` arrive in the same cycle in `S_PLAY`, `ball_lost` wins and the key is ignored.
- Reset mid-game returns immediately (asynchronously) to `S_START` with the reset values above. No `game_restart` is issued until the next key edge.

## Configuration
- `SCREEN_SEQ_BLINK_EN` defined: blink logic as specified above.
- `SCREEN_SEQ_BLINK_EN` undefined: `blink_cnt` is not instantiated and `word_visible` is tied to 1. All other behaviour is unchanged.

## Structure
- Shared `defines` package gets:
  - `typedef enum logic [1:0] screen_t {SCREEN_START=0, SCREEN_GAME=1, SCREEN_END=2}`.
  - Default constants `LIVES_DEFAULT`, `SERVE_FRAMES_DEFAULT`, `END_HOLD_FRAMES_DEFAULT`, `BLINK_FRAMES_DEFAULT`.
- The state enum stays local to this module.
- One sub-module, `frame_timer`:
  - Counts `startOfFrame` pulses up to a parameterised terminal value, with clear, enable and a `done` flag.
  - Instantiated twice: once for `frame_cnt` and once for `blink_cnt`.

## Test plan
- Reset with `key_start` held high, then hold it for 10 cycles → remains in `S_START`, `screen_sel`=0, no `game_restart`.
- Key press in `S_START` → next cycle `screen_sel`=1, `lives`=3, `game_restart` high for 1 cycle, `game_active`=1.
- `ball_lost` in `S_PLAY` with `lives`=3 → `lives`=2, `game_active`=0. After exactly 60 `startOfFrame` pulses → `game_restart` pulse and `game_active`=1.
- Three `ball_lost` events (each after its serve completes) → `screen_sel`=2, `lives`=0. A key press at frame 50 is ignored; a key press at frame 121 → `screen_sel`=0.
- In `S_START` with `SCREEN_SEQ_BLINK_EN` defined → `word_visible` toggles every 30 frames. With it undefined → `word_visible` is constant 1.
- Assert `resetN` low mid-`S_SERVE` → all outputs immediately at their reset values. After release, state is `S_START` with `lives`=0.
